// File: rtl/open_mem_pkg.sv
// Constants shared by the open_mem lane memory and its loader:
// default geometry and the loader FSM state encoding.
package open_mem_pkg;

  localparam int OM_AWIDTH = 2;
  localparam int OM_DWIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [1:0] om_state_t;

endpackage

// File: rtl/mem_lane_loader.sv
// Streams a frame of 2**AWIDTH upstream beats into consecutive open_mem lanes,
// one registered write per accepted beat, with abort and a completion pulse.
module mem_lane_loader
  import open_mem_pkg::*;
#(
  parameter int AWIDTH = OM_AWIDTH,
  parameter int DWIDTH = OM_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_ready,
  output logic              o_wr,
  output logic [AWIDTH-1:0] o_wlane,
  output logic [DWIDTH-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [AWIDTH:0]   o_count
);

  localparam logic [AWIDTH-1:0] LANE_LAST = {AWIDTH{1'b1}};

  om_state_t         state_q, state_d;
  logic [AWIDTH-1:0] lane_q, lane_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              wr_q, wr_d;
  logic [AWIDTH-1:0] wlane_q, wlane_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              ready;
  logic              accept;

  // Ready depends only on state so upstream can never form a loop through i_valid.
  assign ready  = (state_q == ST_FILL);
  assign accept = ready & i_valid;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    count_d = count_q;
    wr_d    = 1'b0;
    wlane_d = wlane_q;
    wdata_d = wdata_q;
    done_d  = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_FILL;
          lane_d  = '0;
          count_d = '0;
        end
      end
      ST_FILL: begin
        // Abort takes priority over a beat presented in the same cycle.
        if (i_abort) begin
          state_d = ST_IDLE;
          lane_d  = '0;
          count_d = '0;
        end else if (accept) begin
          wr_d    = 1'b1;
          wlane_d = lane_q;
          wdata_d = i_data;
          lane_d  = lane_q + 1'b1;
          count_d = count_q + 1'b1;
          if (lane_q == LANE_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      count_q <= '0;
      wr_q    <= 1'b0;
      wlane_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      wlane_q <= wlane_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ready;
  assign o_busy  = (state_q == ST_FILL);
  assign o_wr    = wr_q;
  assign o_wlane = wlane_q;
  assign o_wdata = wdata_q;
  assign o_done  = done_q;
  assign o_count = count_q;

endmodule

// File: doc/mem_lane_loader.md
MEM_LANE_LOADER -- requirements
Module: mem_lane_loader

Interface
REQ-001 Parameter AWIDTH, default 2: lane-index width; frame length N = 2**AWIDTH lanes.
REQ-002 Parameter DWIDTH, default 8: data width per lane.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 i_start  input  1  request to begin filling a frame; sampled only in IDLE.
REQ-006 i_abort  input  1  cancel an in-progress frame; sampled only in FILL.
REQ-007 i_valid  input  1  upstream data beat valid.
REQ-008 i_data  input  DWIDTH  upstream data beat.
REQ-009 o_ready  output  1  loader accepts a beat this cycle.
REQ-010 o_wr  output  1  write strobe to downstream open_mem (i_wr).
REQ-011 o_wlane  output  AWIDTH  lane index to open_mem (i_wlane).
REQ-012 o_wdata  output  DWIDTH  write data to open_mem (i_wdata).
REQ-013 o_busy  output  1  high while state is FILL.
REQ-014 o_done  output  1  one-cycle pulse after the last lane of a frame is written.
REQ-015 o_count  output  AWIDTH+1  lanes accepted in the current frame, 0..N.

Function
REQ-016 FSM states IDLE, FILL, DONE; encoding from the shared package.
REQ-017 IDLE: o_ready=0; i_start=1 -> FILL next cycle, lane counter cleared to 0.
REQ-018 FILL: o_ready=1 combinationally from state (no dependency on i_valid).
REQ-019 Handshake: beat accepted when i_valid=1 and o_ready=1 on a rising edge.
REQ-020 Accepted beat registered: next cycle o_wr=1, o_wlane=lane counter at acceptance, o_wdata=accepted i_data; write latency exactly 1 cycle.
REQ-021 Without an accepted beat, o_wr=0 next cycle; o_wlane/o_wdata hold last values.
REQ-022 Lane counter increments by 1 per accepted beat; o_count = accepted beats this frame.
REQ-023 Beat accepted at lane N-1 -> DONE next cycle (concurrent with its o_wr); counter wraps to 0.
REQ-024 DONE: o_ready=0, lasts exactly one cycle, then IDLE; o_done=1 in the cycle after DONE, coinciding with no write (last write already issued).
REQ-025 i_abort=1 in FILL -> IDLE next cycle; beat presented that cycle not accepted, no o_wr next cycle, no o_done; o_count cleared.
REQ-026 i_abort with final beat in the same cycle: abort wins; no write, no o_done.
REQ-027 i_start outside IDLE ignored; i_abort outside FILL ignored.
REQ-028 i_start and i_valid together in IDLE: beat not accepted (o_ready=0 in IDLE).
REQ-029 Beats need not be consecutive; gaps of any length in FILL allowed.
REQ-030 o_busy=1 exactly while state is FILL.

Reset
REQ-031 rst=0 asynchronously forces IDLE, counter 0, o_wr=0, o_wlane=0, o_wdata=0, o_done=0, o_count=0.
REQ-032 Reset mid-FILL discards the partial frame; no o_wr or o_done generated by it after release.
REQ-033 After rst returns to 1, first i_start is honoured on the first rising edge.

Structure
REQ-034 FSM state encoding and default AWIDTH/DWIDTH constants in shared package open_mem_pkg, also used by open_mem.
REQ-035 Single flat module, no sub-modules; the counter and FSM are local.

Verification
REQ-036 AWIDTH=2, DWIDTH=8, start, beats 0x11,0x22,0x33,0x44 back-to-back -> o_wr on 4 consecutive cycles, lanes 0..3, open_mem o_datalane = {0x44,0x33,0x22,0x11}, one o_done pulse.
REQ-037 Same frame with i_valid idle 3 cycles between beats -> writes at lanes 0..3 only on cycles after acceptance, one o_done.
REQ-038 Start, accept 0xA1,0xB2, assert i_abort with 0xC3 valid -> no write of 0xC3, no o_done, o_count=0, back in IDLE; new frame restarts at lane 0.
REQ-039 i_abort coincident with 4th beat 0x44 -> lane 3 unchanged, no o_done.
REQ-040 rst=0 after 2 beats, mid-cycle -> all outputs 0 immediately; next frame writes from lane 0.
REQ-041 i_start asserted during FILL and i_valid during IDLE -> no effect on counter, writes or state.
